// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared memory-port definitions: op encoding, op type and the
//               default memory geometry used by mem_dma and the memory block.
// Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  typedef logic [1:0] mem_op_t;

  localparam mem_op_t OP_NONE  = 2'd0;
  localparam mem_op_t OP_READ  = 2'd1;
  localparam mem_op_t OP_WRITE = 2'd2;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 64;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_dma
// Description : Word-copy DMA between a read port and a write port of a
//               synchronous memory. Reads src+k on consecutive cycles and
//               writes the returned word to dst+k one cycle later.
//               Optional fill mode (macro MEM_DMA_FILL_EN) writes a latched
//               pattern to dst+k without issuing any reads.
// Revision    : 1.0  initial release
// ============================================================================
module mem_dma
  import mem_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef MEM_DMA_FILL_EN
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_pattern,
`endif
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_rd_op,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [1:0]        o_wr_op,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_ptr;    // next read address
  logic [ADDR_W-1:0] wr_ptr;    // next write address
  logic [ADDR_W:0]   cnt;       // copy: reads left, fill: writes left
  logic              wr_pend;   // a read was issued last cycle, its write is due now
  logic              fill_mode;
  logic              rd_act;
  logic              wr_act;
  logic              last_run;
  logic [DATA_W-1:0] wr_src;

`ifdef MEM_DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] pattern_q;

  // Fill mode and pattern are captured only when a transfer is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fill_q    <= 1'b0;
      pattern_q <= '0;
    end else if (state == ST_IDLE && i_start) begin
      fill_q    <= i_fill;
      pattern_q <= i_pattern;
    end
  end

  assign fill_mode = fill_q;
  assign wr_src    = fill_q ? pattern_q : i_rd_data;
`else
  assign fill_mode = 1'b0;
  assign wr_src    = i_rd_data;
`endif

  // Port activity and end-of-run detection, all decoded from registered state
  always_comb begin
    rd_act   = (state == ST_RUN) && (cnt != '0) && !fill_mode;
    wr_act   = (state == ST_RUN) && (fill_mode || wr_pend);
    // Copy ends on the write-only cycle (no reads left); fill ends on its last write
    last_run = fill_mode ? (cnt == CNT_ONE) : (cnt == '0);
  end

  // Memory port drive: idle ports present NONE with zeroed address and data
  always_comb begin
    o_rd_op   = rd_act ? OP_READ : OP_NONE;
    o_rd_addr = rd_act ? rd_ptr : '0;
    o_wr_op   = wr_act ? OP_WRITE : OP_NONE;
    o_wr_addr = wr_act ? wr_ptr : '0;
    o_wr_data = wr_act ? wr_src : '0;
    o_busy    = (state != ST_IDLE);
    o_done    = (state == ST_DONE);
  end

  // Transfer FSM with inline address pointers and word counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      wr_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_pend <= 1'b0;
          if (i_start) begin
            rd_ptr <= i_src;
            wr_ptr <= i_dst;
            cnt    <= i_len;
            state  <= (i_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          wr_pend <= rd_act;
          if (rd_act) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (wr_act) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (rd_act || fill_mode) begin
            cnt <= cnt - 1'b1;
          end
          if (last_run) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          wr_pend <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          wr_pend <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mem_dma
`default_nettype wire

// File: tb/tb_mem_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_dma
// Description : Scoreboard bench for mem_dma with a synchronous memory model.
//               Fill-mode vectors are built when MEM_DMA_FILL_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_dma;
  import mem_pkg::*;

  localparam int AW = 13;
  localparam int DW = 64;

  localparam logic [DW-1:0] WA = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] WB = 64'hFEDC_BA98_7654_3210;
  localparam logic [DW-1:0] WC = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] WD = 64'h5555_6666_7777_8888;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          busy, done;
  logic [1:0]    rd_op, wr_op;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;
`ifdef MEM_DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] pattern;
`endif

  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t rd_q[$];
  exp_t wr_q[$];
  int   done_q[$];

  mem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
`ifdef MEM_DMA_FILL_EN
    .i_fill    (fill),
    .i_pattern (pattern),
`endif
    .i_start   (start),
    .i_src     (src),
    .i_dst     (dst),
    .i_len     (len),
    .o_busy    (busy),
    .o_done    (done),
    .o_rd_op   (rd_op),
    .o_rd_addr (rd_addr),
    .i_rd_data (rd_data),
    .o_wr_op   (wr_op),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: read data valid the cycle after OP_READ
  always @(posedge clk) begin
    if (rd_op == OP_READ) rd_data <= mem[rd_addr];
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (wr_op == OP_WRITE) mem[wr_addr] <= wr_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an op or done
  always @(negedge clk) begin
    exp_t e;
    int   dc;
    if (mon_en) begin
      if (rd_op == OP_READ) begin
        if (rd_q.size() == 0) flag("unexpected_read");
        else begin
          e = rd_q.pop_front();
          check("rd_addr", 64'(rd_addr), 64'(e.addr));
          check("rd_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (rd_op == OP_NONE) check("rd_idle_addr", 64'(rd_addr), 64'd0);
      else flag("rd_illegal_op");

      if (wr_op == OP_WRITE) begin
        if (wr_q.size() == 0) flag("unexpected_write");
        else begin
          e = wr_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", wr_data, e.data);
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (wr_op == OP_NONE) begin
        check("wr_idle_addr", 64'(wr_addr), 64'd0);
        check("wr_idle_data", wr_data, 64'd0);
      end else flag("wr_illegal_op");

      if (done) begin
        if (done_q.size() == 0) flag("unexpected_done");
        else begin
          dc = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(dc));
        end
      end
    end
  end

  task automatic exp_rd(input int c, input logic [AW-1:0] a);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = '0;
    rd_q.push_back(e);
  endtask

  task automatic exp_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Raises start with arguments; c is the cycle in which start is presented
  task automatic drive_start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [AW:0] l, input bit f, input logic [DW-1:0] p,
                             output int c);
    @(negedge clk); #1;
    start = 1'b1; src = s; dst = d; len = l;
`ifdef MEM_DMA_FILL_EN
    fill = f; pattern = p;
`else
    if (f || (p != '0)) $display("note: fill arguments ignored in this build");
`endif
    c = cyc;
  endtask

  task automatic end_start();
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0; pattern = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rd_op", 64'(rd_op), 64'd0);
    check("reset_wr_op", 64'(wr_op), 64'd0);
    check("reset_wr_data", wr_data, 64'd0);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    poke(13'h010, WA); poke(13'h011, WB); poke(13'h012, WC); poke(13'h013, WD);
    poke(13'h1FFE, 64'h0000_0000_0000_1FFE); poke(13'h1FFF, 64'h0000_0000_0000_1FFF);
    poke(13'h0000, 64'hAAAA_0000_0000_0000); poke(13'h0001, 64'hAAAA_0000_0000_0001);
    poke(13'h040, 64'h4040_4040_4040_4040); poke(13'h041, 64'h4141_4141_4141_4141);
    poke(13'h042, 64'h4242_4242_4242_4242);
    poke(13'h200, 64'h2000_0000_0000_0000); poke(13'h201, 64'h2010_0000_0000_0000);
    poke(13'h202, 64'h2020_0000_0000_0000);

    // Basic copy of four words
    drive_start(13'h010, 13'h100, 14'd4, 1'b0, '0, c);
    for (int k = 0; k < 4; k++) exp_rd(c + 1 + k, 13'(13'h010 + k));
    exp_wr(c + 2, 13'h100, WA); exp_wr(c + 3, 13'h101, WB);
    exp_wr(c + 4, 13'h102, WC); exp_wr(c + 5, 13'h103, WD);
    done_q.push_back(c + 6);
    end_start();
    wait_until(c + 3); check("copy_busy_run", 64'(busy), 64'd1);
    wait_until(c + 6); check("copy_busy_done", 64'(busy), 64'd1);
    wait_until(c + 7); check("copy_busy_idle", 64'(busy), 64'd0);
    wait_until(c + 8);
    check("copy_mem_100", mem[13'h100], WA);
    check("copy_mem_103", mem[13'h103], WD);

    // Zero-length transfer
    drive_start(13'h123, 13'h456, 14'd0, 1'b0, '0, c);
    done_q.push_back(c + 1);
    end_start();
    check("len0_busy", 64'(busy), 64'd1);
    wait_until(c + 2); check("len0_busy_after", 64'(busy), 64'd0);
    wait_until(c + 4);

    // Source address wrap
    drive_start(13'h1FFE, 13'h0800, 14'd4, 1'b0, '0, c);
    exp_rd(c + 1, 13'h1FFE); exp_rd(c + 2, 13'h1FFF);
    exp_rd(c + 3, 13'h0000); exp_rd(c + 4, 13'h0001);
    exp_wr(c + 2, 13'h0800, 64'h0000_0000_0000_1FFE);
    exp_wr(c + 3, 13'h0801, 64'h0000_0000_0000_1FFF);
    exp_wr(c + 4, 13'h0802, 64'hAAAA_0000_0000_0000);
    exp_wr(c + 5, 13'h0803, 64'hAAAA_0000_0000_0001);
    done_q.push_back(c + 6);
    end_start();
    wait_until(c + 8);

    // Start pulsed mid-transfer is ignored
    begin
      int c2;
      drive_start(13'h040, 13'h140, 14'd3, 1'b0, '0, c);
      for (int k = 0; k < 3; k++) exp_rd(c + 1 + k, 13'(13'h040 + k));
      exp_wr(c + 2, 13'h140, 64'h4040_4040_4040_4040);
      exp_wr(c + 3, 13'h141, 64'h4141_4141_4141_4141);
      exp_wr(c + 4, 13'h142, 64'h4242_4242_4242_4242);
      done_q.push_back(c + 5);
      end_start();
      drive_start(13'h050, 13'h150, 14'd5, 1'b0, '0, c2);
      end_start();
      wait_until(c + 9);
    end

    // Reset after the second write of an eight-word copy
    drive_start(13'h200, 13'h300, 14'd8, 1'b0, '0, c);
    exp_rd(c + 1, 13'h200); exp_rd(c + 2, 13'h201); exp_rd(c + 3, 13'h202);
    exp_wr(c + 2, 13'h300, 64'h2000_0000_0000_0000);
    exp_wr(c + 3, 13'h301, 64'h2010_0000_0000_0000);
    end_start();
    wait_until(c + 3);
    #1 rst = 1'b1;
    start = 1'b1; src = 13'h010; dst = 13'h500; len = 14'd2;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    #1 rst = 1'b0; start = 1'b0;
    wait_until(c + 8);
    check("rst_busy_later", 64'(busy), 64'd0);

    drive_start(13'h010, 13'h600, 14'd2, 1'b0, '0, c);
    exp_rd(c + 1, 13'h010); exp_rd(c + 2, 13'h011);
    exp_wr(c + 2, 13'h600, WA); exp_wr(c + 3, 13'h601, WB);
    done_q.push_back(c + 4);
    end_start();
    wait_until(c + 6);
    check("post_rst_mem_601", mem[13'h601], WB);

`ifdef MEM_DMA_FILL_EN
    // Fill three words with a pattern, no reads
    drive_start(13'h000, 13'h020, 14'd3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, c);
    for (int k = 0; k < 3; k++) exp_wr(c + 1 + k, 13'(13'h020 + k), 64'hDEAD_BEEF_CAFE_F00D);
    done_q.push_back(c + 4);
    end_start();
    wait_until(c + 6);
    check("fill_mem_022", mem[13'h022], 64'hDEAD_BEEF_CAFE_F00D);
`endif

    repeat (2) @(negedge clk);
    check("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_dma
`default_nettype wire

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory word-address width (8192 words).
REQ-002 SHALL have parameter DATA_W, default 64, memory word width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1, one-cycle request to begin a transfer.
REQ-006 SHALL have port i_src, input, ADDR_W, source start word address.
REQ-007 SHALL have port i_dst, input, ADDR_W, destination start word address.
REQ-008 SHALL have port i_len, input, ADDR_W+1, word count, 0..8192.
REQ-009 SHALL have port o_busy, output, 1, high while a transfer is in progress.
REQ-010 SHALL have port o_done, output, 1, one-cycle pulse on transfer completion.
REQ-011 SHALL have port o_rd_op, output, 2, op for the read memory port.
REQ-012 SHALL have port o_rd_addr, output, ADDR_W, read address.
REQ-013 SHALL have port i_rd_data, input, DATA_W, read data, valid the cycle after OP_READ.
REQ-014 SHALL have port o_wr_op, output, 2, op for the write memory port.
REQ-015 SHALL have port o_wr_addr, output, ADDR_W, write address.
REQ-016 SHALL have port o_wr_data, output, DATA_W, write data.

Function
REQ-017 SHALL use op encoding NONE=0, READ=1, WRITE=2; it SHALL never drive 3.
REQ-018 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-019 IDLE: on i_start with i_len>0, SHALL latch i_src, i_dst and i_len, and enter RUN next cycle; with i_len=0, SHALL enter DONE directly and issue no memory op.
REQ-020 RUN: SHALL issue OP_READ at src+k for k=0..len-1 on consecutive cycles, one per cycle, with no bubbles.
REQ-021 SHALL issue OP_WRITE at dst+k with o_wr_data=i_rd_data exactly one cycle after the read of src+k.
REQ-022 Write data SHALL be a combinational pass-through of i_rd_data; no extra register stage.
REQ-023 RUN SHALL last len+1 cycles: the first cycle is read-only, the last cycle is write-only, and the cycles between overlap a read and a write.
REQ-024 After the final write, SHALL enter DONE; DONE SHALL assert o_done for exactly one cycle and then return to IDLE.
REQ-025 o_busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-026 i_start SHALL be ignored while o_busy is high.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W; 8191+1 wraps to 0.
REQ-028 When a port is inactive, its op SHALL be NONE, and its addr and data SHALL be 0.
REQ-029 Results SHALL be defined only for dst<=src or non-overlapping ranges; for overlapping ranges with dst>src, memory contents are unspecified.

Reset
REQ-030 i_rst SHALL force IDLE, with o_busy=0, o_done=0, both ops NONE, and all addresses and data 0, in the cycle after the asserting edge.
REQ-031 Reset mid-transfer SHALL abandon it, issue no further reads or writes, and not pulse o_done.
REQ-032 i_start coincident with i_rst SHALL be ignored.

Configuration
REQ-033 With macro MEM_DMA_FILL_EN defined, the block SHALL add ports i_fill (in, 1) and i_pattern (in, DATA_W), both latched with i_start.
REQ-034 When fill mode is selected (fill=1), the block SHALL issue no reads, SHALL write i_pattern to dst+k on consecutive cycles, and RUN SHALL last exactly len cycles.
REQ-035 Without MEM_DMA_FILL_EN, the fill ports SHALL be absent, and only copy mode SHALL exist.

Structure
REQ-036 Package mem_pkg SHALL hold OP_NONE, OP_READ, OP_WRITE, a mem_op_t 2-bit typedef, MEM_ADDR_W=13 and MEM_DATA_W=64, shared with the memory block.
REQ-037 The block SHALL be a single module with no sub-module; the FSM and counters are inline.

Verification
REQ-038 Copy, src=0x010, dst=0x100, len=4, memory preloaded with A,B,C,D: reads at cycles 1-4, writes 0x100-0x103 at cycles 2-5, o_done at cycle 6, memory 0x100-0x103 = A,B,C,D.
REQ-039 len=0 start: no ops issued, o_busy high for 1 cycle, o_done pulses one cycle after start.
REQ-040 Wrap, src=0x1FFE, dst=0x0800, len=4: reads 0x1FFE, 0x1FFF, 0x0000, 0x0001 in order.
REQ-041 Start pulsed during RUN with different arguments: ignored; the original transfer completes unchanged.
REQ-042 i_rst asserted after the 2nd write of a len=8 copy: no further writes, o_done stays low, o_busy=0 next cycle, then a new start works normally.
REQ-043 With MEM_DMA_FILL_EN, fill=1, pattern=0xDEADBEEF_CAFEF00D, dst=0x20, len=3: no reads, 3 writes at 0x20-0x22, o_done on the 4th cycle after start.
